// File: rtl/fetch_stage_if.sv
// Bundle of fetch-stage signals: instruction-memory bus, decode redirect
// inputs and the IF/ID register outputs.
// Optional macro FETCH_PERF_CNT_EN adds the two performance counter outputs.
interface fetch_stage_if;
    logic        stall_f;
    logic [2:0]  pc_signal_d;
    logic        branch_taken_d;
    logic [31:0] branch_target_d;
    logic [31:0] jr_target_d;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    // Fetch stage side
    modport master (
        input  stall_f,
        input  pc_signal_d,
        input  branch_taken_d,
        input  branch_target_d,
        input  jr_target_d,
        input  imem_rdata,
        output imem_addr,
        output instruction_d,
        output pc_plus4_d,
        output valid_d,
        output halted
`ifdef FETCH_PERF_CNT_EN
        ,
        output perf_fetch_cnt,
        output perf_bubble_cnt
`endif
    );

    // Memory / decode / hazard side
    modport slave (
        output stall_f,
        output pc_signal_d,
        output branch_taken_d,
        output branch_target_d,
        output jr_target_d,
        output imem_rdata,
        input  imem_addr,
        input  instruction_d,
        input  pc_plus4_d,
        input  valid_d,
        input  halted
`ifdef FETCH_PERF_CNT_EN
        ,
        input  perf_fetch_cnt,
        input  perf_bubble_cnt
`endif
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Holds the PC, applies decode redirects with a one-bubble penalty and stops
// fetching after a halt word (32'hFFFF_FFFF) has drained the pipeline.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/bubble counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);
    localparam logic [31:0] HaltWord = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] redirect_target;
    logic        redirect;
    logic        halt_enter;
    logic        fetch_en;

    // Redirect decode and halt detection
    always_comb begin
        pc_plus4        = pc_q + 32'd4;
        jump_target     = {ifid_pc4_q[31:28], ifid_instr_q[25:0], 2'b00};
        redirect        = 1'b0;
        redirect_target = pc_plus4;
        case (bus.pc_signal_d)
            3'b001: begin
                redirect        = 1'b1;
                redirect_target = jump_target;
            end
            3'b010: begin
                redirect        = bus.branch_taken_d;
                redirect_target = bus.branch_target_d;
            end
            3'b011: begin
                redirect        = 1'b1;
                redirect_target = bus.jr_target_d;
            end
            default: ;
        endcase
        // The halt word never reaches decode as a real instruction
        halt_enter = (state_q == StRun) && ifid_valid_q && (ifid_instr_q == HaltWord) &&
                     !bus.stall_f;
        fetch_en   = (state_q == StRun) && !halt_enter;
    end

    // Next PC and IF/ID contents
    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        if (!fetch_en) begin
            ifid_instr_d = '0;
            ifid_pc4_d   = '0;
            ifid_valid_d = 1'b0;
        end else if (bus.stall_f) begin
            // stall beats redirect; decode keeps presenting it
        end else if (redirect) begin
            pc_d         = redirect_target;
            ifid_instr_d = '0;
            ifid_pc4_d   = '0;
            ifid_valid_d = 1'b0;
        end else begin
            pc_d         = pc_plus4;
            ifid_instr_d = bus.imem_rdata;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
        end
    end

    // PC and IF/ID registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // FSM state and drain counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: DRAIN lasts exactly DRAIN_CYCLES edges
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (halt_enter) begin
                    state_d = StDrain;
                    cnt_d   = 32'(DRAIN_CYCLES - 1);
                end
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    state_d = StHalt;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StRun;
        endcase
    end

    // FSM and register outputs
    always_comb begin
        bus.halted        = (state_q == StHalt);
        bus.imem_addr     = pc_q;
        bus.instruction_d = ifid_instr_q;
        bus.pc_plus4_d    = ifid_pc4_q;
        bus.valid_d       = ifid_valid_q;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;
    logic        fetch_inc, bubble_inc;

    // Saturating counters; only RUN edges can count
    always_comb begin
        fetch_inc     = fetch_en && !bus.stall_f && !redirect;
        bubble_inc    = (state_q == StRun) && !fetch_inc;
        perf_fetch_d  = perf_fetch_q;
        perf_bubble_d = perf_bubble_q;
        if (fetch_inc && (perf_fetch_q != 32'hFFFF_FFFF)) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        if (bubble_inc && (perf_bubble_q != 32'hFFFF_FFFF)) begin
            perf_bubble_d = perf_bubble_q + 32'd1;
        end
        bus.perf_fetch_cnt  = perf_fetch_q;
        bus.perf_bubble_cnt = perf_bubble_q;
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            perf_fetch_q  <= perf_fetch_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a small PC/IF-ID model pushes the
// expected IF/ID contents into a scoreboard each cycle; halt is checked directly.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC     (32'h0000_0000),
        .DRAIN_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    logic [31:0] mem [256];
    assign bus.imem_rdata = mem[bus.imem_addr[9:2]];

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    ifid_t       sb_q[$];
    logic [31:0] exp_pc;
    ifid_t       exp_ifid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.stall_f         = 1'b0;
        bus.pc_signal_d     = 3'b000;
        bus.branch_taken_d  = 1'b0;
        bus.branch_target_d = 32'h0;
        bus.jr_target_d     = 32'h0;
    endtask

    // Reset entered at a negedge; checks asynchronous effect and held values
    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_addr", bus.imem_addr, 32'h0);
        check_eq("async_rst_halted", {31'b0, bus.halted}, 32'h0);
        check_eq("async_rst_valid", {31'b0, bus.valid_d}, 32'h0);
        repeat (3) @(negedge clk);
        check_eq("rst_addr", bus.imem_addr, 32'h0);
        check_eq("rst_instr", bus.instruction_d, 32'h0);
        check_eq("rst_pc4", bus.pc_plus4_d, 32'h0);
        exp_pc   = 32'h0;
        exp_ifid = '{32'h0, 32'h0, 1'b0};
        sb_q.delete();
        rst_n = 1'b1;
    endtask

    // One RUN cycle: drive decode inputs, predict, clock, compare IF/ID
    task automatic step(input logic stall, input logic [2:0] sig, input logic taken,
                        input logic [31:0] btgt, input logic [31:0] jtgt);
        ifid_t       want;
        logic        take;
        logic [31:0] tgt;
        check_eq("imem_addr", bus.imem_addr, exp_pc);
        check_eq("halted_low", {31'b0, bus.halted}, 32'h0);
        bus.stall_f         = stall;
        bus.pc_signal_d     = sig;
        bus.branch_taken_d  = taken;
        bus.branch_target_d = btgt;
        bus.jr_target_d     = jtgt;
        take = (sig == 3'b001) || (sig == 3'b011) || ((sig == 3'b010) && taken);
        if (sig == 3'b001) tgt = {exp_ifid.pc4[31:28], exp_ifid.instr[25:0], 2'b00};
        else if (sig == 3'b010) tgt = btgt;
        else tgt = jtgt;
        if (stall) begin
            // IF/ID and PC hold
        end else if (take) begin
            exp_ifid = '{32'h0, 32'h0, 1'b0};
            exp_pc   = tgt;
        end else begin
            exp_ifid = '{mem[exp_pc[9:2]], exp_pc + 32'd4, 1'b1};
            exp_pc   = exp_pc + 32'd4;
        end
        sb_q.push_back(exp_ifid);
        @(negedge clk);
        want = sb_q.pop_front();
        check_eq("ifid_instr", bus.instruction_d, want.instr);
        check_eq("ifid_pc4", bus.pc_plus4_d, want.pc4);
        check_eq("ifid_valid", {31'b0, bus.valid_d}, {31'b0, want.valid});
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'b000, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h2400_0000 | i;
        mem[3] = 32'h0800_0040;  // j 0x40 at 0xC
        rst_n  = 1'b0;
        @(negedge clk);
        do_reset();

        // Sequential from reset, j fetched at 0xC
        seq(4);
        // Jump: target 0x100, one bubble, then mem[0x100]
        step(1'b0, 3'b001, 1'b0, 32'h0, 32'h0);
        seq(1);
        // Branch not taken, then taken to 0x20
        step(1'b0, 3'b010, 1'b0, 32'h300, 32'h0);
        step(1'b0, 3'b010, 1'b1, 32'h20, 32'h0);
        seq(1);
        // Stall holds jr; applied on first unstalled edge
        step(1'b1, 3'b011, 1'b0, 32'h0, 32'h80);
        step(1'b1, 3'b011, 1'b0, 32'h0, 32'h80);
        step(1'b0, 3'b011, 1'b0, 32'h0, 32'h80);
        seq(1);
        // Undefined selects behave as sequential
        step(1'b0, 3'b100, 1'b1, 32'h300, 32'h300);
        step(1'b0, 3'b111, 1'b1, 32'h300, 32'h300);
        // PC wrap-around
        step(1'b0, 3'b011, 1'b0, 32'h0, 32'hFFFF_FFFC);
        seq(2);
        // Halt word in the wrong-path slot behind a taken branch
        mem[exp_pc[9:2]] = 32'hFFFF_FFFF;
        step(1'b0, 3'b010, 1'b1, 32'h40, 32'h0);
        seq(6);
        for (int i = 0; i < 256; i++) mem[i] = 32'h2400_0000 | i;

        // Halt at 0xC with DRAIN_CYCLES=4
        mem[3] = 32'hFFFF_FFFF;
        do_reset();
        seq(4);
        step(1'b1, 3'b000, 1'b0, 32'h0, 32'h0);  // stalled halt word does not enter DRAIN
        drive_idle();
        @(negedge clk);  // entry edge
        check_eq("halt_entry_addr", bus.imem_addr, 32'h10);
        check_eq("halt_entry_valid", {31'b0, bus.valid_d}, 32'h0);
        check_eq("halt_entry_instr", bus.instruction_d, 32'h0);
        check_eq("halt_entry_halted", {31'b0, bus.halted}, 32'h0);
        for (int i = 1; i <= 6; i++) begin
            if (i >= 2) begin
                bus.stall_f     = 1'b1;
                bus.pc_signal_d = 3'b011;
                bus.jr_target_d = 32'h200;
            end
            @(negedge clk);
            check_eq("drain_addr", bus.imem_addr, 32'h10);
            check_eq("drain_valid", {31'b0, bus.valid_d}, 32'h0);
            check_eq("drain_halted", {31'b0, bus.halted}, (i >= 4) ? 32'h1 : 32'h0);
        end

        // Reset in the middle of DRAIN restarts RUN at 0x0
        do_reset();
        seq(4);
        drive_idle();
        repeat (3) @(negedge clk);
        check_eq("mid_drain_halted", {31'b0, bus.halted}, 32'h0);
        mem[3] = 32'h2400_0003;
        do_reset();
        seq(8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
